alu_seq_ctrl: RTL

- Sequencer that shares one (W+2)-bit adder among four operations: signed add/sub, signed multiply (radix-2 Booth), and unsigned divide (non-restoring).
- Sits between the instruction/decode logic and the shared adder.
- Accepts one operation at a time, iterates the adder once per cycle, and returns a 2W-bit result with a one-cycle done pulse.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_ctrl_if.sv | 32 +++
 rtl/alu_seq_ctrl_shared_adder.sv | 19 +
 rtl/alu_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : op encodings, sequencer state type and default width
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADD     = 3'd1,
    ST_MUL     = 3'd2,
    ST_DIV     = 3'd3,
    ST_DIV_FIX = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if : request / result bundle between decode and the sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if #(
  parameter int W = alu_pkg::W_DEFAULT
);

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         cout;
  logic         div_zero;

  modport master (
    output start, op, a, b,
    input  ready, done, result_lo, result_hi, cout, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result_lo, result_hi, cout, div_zero
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl_shared_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shared_adder : plain N-bit combinational adder with carry in/out
// Rev 1.0
// ---------------------------------------------------------------------------
module shared_adder #(
  parameter int N = 34
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_ctrl : add/sub, Booth multiply and non-restoring divide sharing
//                a single (W+2)-bit adder, one iteration per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus
);

  localparam int            N        = W + 2;
  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic          sub_q, sub_d;
  logic [N-1:0]  p_q, p_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic          qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic          cout_q, cout_d;
  logic          dz_q, dz_d;

  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout_unused;
  logic [W-1:0]  m_x;
  logic [N-1:0]  m_sext, m_zext;
  logic          booth_add, booth_sub, cnt_last;

  // q holds A (or the multiplier), m holds B (or the multiplicand)
  assign m_x       = m_q ^ {W{sub_q}};
  assign m_sext    = {{2{m_q[W-1]}}, m_q};
  assign m_zext    = {2'b00, m_q};
  assign booth_add = ~q_q[0] & qm1_q;
  assign booth_sub = q_q[0] & ~qm1_q;
  assign cnt_last  = (cnt_q == CNT_LAST);

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      ST_ADD: begin
        add_a   = {{2{q_q[W-1]}}, q_q};
        add_b   = {{2{m_x[W-1]}}, m_x};
        add_cin = sub_q;
      end
      ST_MUL: begin
        add_a = p_q;
        if (booth_add) begin
          add_b = m_sext;
        end else if (booth_sub) begin
          add_b   = ~m_sext;
          add_cin = 1'b1;
        end
      end
      ST_DIV: begin
        // shifted remainder 2R+q_msb is exact in N bits
        add_a = {p_q[W:0], q_q[W-1]};
        if (!p_q[N-1]) begin
          add_b   = ~m_zext;
          add_cin = 1'b1;
        end else begin
          add_b = m_zext;
        end
      end
      ST_DIV_FIX: begin
        add_a = p_q;
        if (p_q[N-1]) add_b = m_zext;
      end
      default: ;
    endcase
  end

  shared_adder #(.N(N)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout_unused)
  );

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    p_d     = p_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cout_d  = cout_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sub_d  = (bus.op == OP_SUB);
          p_d    = '0;
          qm1_d  = 1'b0;
          cnt_d  = '0;
          cout_d = 1'b0;
          dz_d   = 1'b0;
          case (bus.op)
            OP_MUL: begin
              q_d     = bus.b;
              m_d     = bus.a;
              state_d = ST_MUL;
            end
            OP_DIV: begin
              q_d = bus.a;
              m_d = bus.b;
              if (bus.b == '0) begin
                dz_d    = 1'b1;
                lo_d    = '1;
                hi_d    = bus.a;
                state_d = ST_DONE;
              end else begin
                state_d = ST_DIV;
              end
            end
            default: begin
              q_d     = bus.a;
              m_d     = bus.b;
              state_d = ST_ADD;
            end
          endcase
        end
      end
      ST_ADD: begin
        lo_d    = add_sum[W-1:0];
        hi_d    = {W{add_sum[W]}};
        // carry into bit W recovered from the sign-extended sum
        cout_d  = add_sum[W] ^ add_a[W] ^ add_b[W];
        state_d = ST_DONE;
      end
      ST_MUL: begin
        p_d   = {add_sum[N-1], add_sum[N-1:1]};
        q_d   = {add_sum[0], q_q[W-1:1]};
        qm1_d = q_q[0];
        if (cnt_last) begin
          cnt_d   = '0;
          lo_d    = {add_sum[0], q_q[W-1:1]};
          hi_d    = add_sum[W:1];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV: begin
        p_d = add_sum;
        q_d = {q_q[W-2:0], ~add_sum[N-1]};
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_DIV_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DIV_FIX: begin
        p_d     = add_sum;
        lo_d    = q_q;
        hi_d    = add_sum[W-1:0];
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sub_q   <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      p_q     <= p_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.cout      = cout_q;
  assign bus.div_zero  = dz_q;

endmodule
`default_nettype wire
